// File: rtl/syn_fft_pkg.sv
// Shared types and sizes for the FFT engine: sample/twiddle formats, host mode and
// sequencer states.
package syn_fft_pkg;

    localparam int P_FFT_NUM_SAMPLES = 128;
    localparam int P_FFT_ADDR_W      = 7;
    localparam int P_FFT_TWDL_W      = 10;

    typedef enum logic {
        NORMAL = 1'b0,
        CONFIG = 1'b1
    } fgyrus_mode_t;

    typedef struct packed {
        logic [P_FFT_TWDL_W-1:0] re;
        logic [P_FFT_TWDL_W-1:0] im;
    } fft_twdl_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fft_seq_state_t;

endpackage

// File: rtl/syn_fft_seq_if.sv
// Bundle between the FFT sequencer and its memories/datapath: sample RAM read and
// write-back ports, butterfly valid, twiddle read index, host twiddle load path.
interface syn_fft_seq_if
    import syn_fft_pkg::*;
#(
    parameter int P_ADDR_W = P_FFT_ADDR_W
);

    // Every *_en / *_vld strobe is valid-only: there is no ready, so the receiver must
    // take each strobed beat in the cycle it is presented, with its address/data.
    logic                  sram_rd_en_o;
    logic [P_ADDR_W-1:0]   sram_rd_addr_a_o;
    logic [P_ADDR_W-1:0]   sram_rd_addr_b_o;
    logic [P_ADDR_W-2:0]   twdl_rd_addr_o;
    logic                  bfly_vld_o;
    logic                  sram_wr_en_o;
    logic [P_ADDR_W-1:0]   sram_wr_addr_a_o;
    logic [P_ADDR_W-1:0]   sram_wr_addr_b_o;
    logic                  cfg_twdl_wr_en_i;
    logic [P_ADDR_W-2:0]   cfg_twdl_addr_i;
    fft_twdl_t             cfg_twdl_data_i;
    logic                  twdl_wr_en_o;
    logic [P_ADDR_W-2:0]   twdl_wr_addr_o;
    fft_twdl_t             twdl_wr_data_o;

    modport master (
        output sram_rd_en_o, sram_rd_addr_a_o, sram_rd_addr_b_o, twdl_rd_addr_o,
        output bfly_vld_o, sram_wr_en_o, sram_wr_addr_a_o, sram_wr_addr_b_o,
        output twdl_wr_en_o, twdl_wr_addr_o, twdl_wr_data_o,
        input  cfg_twdl_wr_en_i, cfg_twdl_addr_i, cfg_twdl_data_i
    );

    modport slave (
        input  sram_rd_en_o, sram_rd_addr_a_o, sram_rd_addr_b_o, twdl_rd_addr_o,
        input  bfly_vld_o, sram_wr_en_o, sram_wr_addr_a_o, sram_wr_addr_b_o,
        input  twdl_wr_en_o, twdl_wr_addr_o, twdl_wr_data_o,
        output cfg_twdl_wr_en_i, cfg_twdl_addr_i, cfg_twdl_data_i
    );

endinterface

// File: rtl/syn_fft_addr_gen.sv
// Radix-2 DIT in-place addressing: maps (stage, butterfly index) to the operand pair
// and the twiddle index. Purely combinational.
module syn_fft_addr_gen
    import syn_fft_pkg::*;
#(
    parameter int P_ADDR_W = P_FFT_ADDR_W,
    parameter int P_S_W    = $clog2(P_FFT_ADDR_W)
) (
    input  logic [P_S_W-1:0]    stage,
    input  logic [P_ADDR_W-2:0] bfly,
    output logic [P_ADDR_W-1:0] addr_a,
    output logic [P_ADDR_W-1:0] addr_b,
    output logic [P_ADDR_W-2:0] twdl_idx
);

    localparam logic [P_ADDR_W-1:0] ONE    = P_ADDR_W'(1);
    localparam logic [P_S_W-1:0]    S_LAST = P_S_W'(P_ADDR_W - 1);

    logic [P_ADDR_W-1:0] j_ext;
    logic [P_ADDR_W-1:0] span;
    logic [P_ADDR_W-1:0] k;

    // Group base is j with its low s bits removed and shifted up by s+1; k is the
    // offset inside the group and also selects the twiddle, scaled to N/2 entries.
    always_comb begin
        j_ext    = {1'b0, bfly};
        span     = ONE << stage;
        k        = j_ext & (span - ONE);
        addr_a   = (((j_ext >> stage) << stage) << 1) | k;
        addr_b   = addr_a + span;
        twdl_idx = k[P_ADDR_W-2:0] << (S_LAST - stage);
    end

endmodule

// File: rtl/syn_fft_seq.sv
// FFT sequencer: walks every radix-2 stage issuing one butterfly read per cycle,
// replays the addresses as write-backs after the butterfly latency, and forwards host
// twiddle loads while idle in CONFIG mode.
module syn_fft_seq
    import syn_fft_pkg::*;
#(
    parameter int P_NUM_SAMPLES = P_FFT_NUM_SAMPLES,
    parameter int P_ADDR_W      = P_FFT_ADDR_W,
    parameter int P_BFLY_LAT    = 4
) (
    input  logic           clk_ir,
    input  logic           rst_ih,
    input  fgyrus_mode_t   fgyrus_mode_i,
    input  logic           start_i,
    output logic           busy_o,
    output logic           done_o,
    output fft_seq_state_t state_dbg,
    syn_fft_seq_if.master  bus
);

    localparam int D   = P_BFLY_LAT + 1;
    localparam int S_W = $clog2(P_ADDR_W);
    localparam int J_W = P_ADDR_W - 1;
    localparam int C_W = $clog2(D + 1);

    localparam logic [J_W-1:0] J_LAST = J_W'(P_NUM_SAMPLES / 2 - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(P_ADDR_W - 1);
    localparam logic [C_W-1:0] C_LAST = C_W'(D - 1);

    fft_seq_state_t state, state_nxt;
    logic [S_W-1:0] stage, stage_nxt;
    logic [J_W-1:0] bfly, bfly_nxt;
    logic [C_W-1:0] drain_cnt, drain_cnt_nxt;

    logic                rd_en;
    logic [P_ADDR_W-1:0] gen_a;
    logic [P_ADDR_W-1:0] gen_b;
    logic [P_ADDR_W-2:0] gen_tw;
    logic                twdl_accept;

    logic [D-1:0]                dl_en;
    logic [D-1:0][P_ADDR_W-1:0]  dl_a;
    logic [D-1:0][P_ADDR_W-1:0]  dl_b;

    syn_fft_addr_gen #(
        .P_ADDR_W (P_ADDR_W),
        .P_S_W    (S_W)
    ) u_addr_gen (
        .stage    (stage),
        .bfly     (bfly),
        .addr_a   (gen_a),
        .addr_b   (gen_b),
        .twdl_idx (gen_tw)
    );

    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            state     <= IDLE;
            stage     <= '0;
            bfly      <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            stage     <= stage_nxt;
            bfly      <= bfly_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Mode and start are only looked at in IDLE, so changes while busy are inert.
    always_comb begin
        state_nxt     = state;
        stage_nxt     = stage;
        bfly_nxt      = bfly;
        drain_cnt_nxt = drain_cnt;
        case (state)
            IDLE: begin
                if (start_i && fgyrus_mode_i == NORMAL) begin
                    state_nxt = ISSUE;
                    stage_nxt = '0;
                    bfly_nxt  = '0;
                end
            end
            ISSUE: begin
                if (bfly == J_LAST) begin
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = '0;
                end else begin
                    bfly_nxt = bfly + J_W'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == C_LAST) begin
                    if (stage == S_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ISSUE;
                        stage_nxt = stage + S_W'(1);
                        bfly_nxt  = '0;
                    end
                end else begin
                    drain_cnt_nxt = drain_cnt + C_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rd_en                = (state == ISSUE);
    assign busy_o               = (state != IDLE);
    assign done_o               = (state == DONE);
    assign state_dbg            = state;
    assign bus.sram_rd_en_o     = rd_en;
    assign bus.sram_rd_addr_a_o = rd_en ? gen_a : '0;
    assign bus.sram_rd_addr_b_o = rd_en ? gen_b : '0;
    assign bus.twdl_rd_addr_o   = rd_en ? gen_tw : '0;

    // Tap 0 lines up with the 1-cycle RAM read; the last tap is the write-back slot.
    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            dl_en <= '0;
            dl_a  <= '0;
            dl_b  <= '0;
        end else begin
            dl_en[0] <= rd_en;
            dl_a[0]  <= bus.sram_rd_addr_a_o;
            dl_b[0]  <= bus.sram_rd_addr_b_o;
            for (int i = 1; i < D; i++) begin
                dl_en[i] <= dl_en[i-1];
                dl_a[i]  <= dl_a[i-1];
                dl_b[i]  <= dl_b[i-1];
            end
        end
    end

    assign bus.bfly_vld_o       = dl_en[0];
    assign bus.sram_wr_en_o     = dl_en[D-1];
    assign bus.sram_wr_addr_a_o = dl_a[D-1];
    assign bus.sram_wr_addr_b_o = dl_b[D-1];

    assign twdl_accept = bus.cfg_twdl_wr_en_i && (fgyrus_mode_i == CONFIG) && (state == IDLE);

    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            bus.twdl_wr_en_o   <= 1'b0;
            bus.twdl_wr_addr_o <= '0;
            bus.twdl_wr_data_o <= '0;
        end else begin
            bus.twdl_wr_en_o <= twdl_accept;
            if (twdl_accept) begin
                bus.twdl_wr_addr_o <= bus.cfg_twdl_addr_i;
                bus.twdl_wr_data_o <= bus.cfg_twdl_data_i;
            end
        end
    end

endmodule

// File: tb/tb_syn_fft_seq.sv
// Directed bench for syn_fft_seq: full-schedule scoreboard of reads and write-backs,
// busy/done timing, ignored start/mode changes, twiddle pass-through and mid-run reset.
module tb_syn_fft_seq;
    import syn_fft_pkg::*;

    localparam int N      = 128;
    localparam int AW     = 7;
    localparam int D      = 5;
    localparam int HALF   = N / 2;
    localparam int STG    = HALF + D;
    localparam int T_DONE = 1 + AW * STG;

    logic           clk = 1'b0;
    logic           rst;
    fgyrus_mode_t   mode;
    logic           start;
    logic           busy;
    logic           done;
    fft_seq_state_t state_dbg;

    syn_fft_seq_if #(.P_ADDR_W(AW)) bus ();

    syn_fft_seq #(
        .P_NUM_SAMPLES (N),
        .P_ADDR_W      (AW),
        .P_BFLY_LAT    (4)
    ) dut (
        .clk_ir        (clk),
        .rst_ih        (rst),
        .fgyrus_mode_i (mode),
        .start_i       (start),
        .busy_o        (busy),
        .done_o        (done),
        .state_dbg     (state_dbg),
        .bus           (bus)
    );

    // clock / cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int        checks   = 0;
    int        failures = 0;
    int        t0       = 0;
    bit        mon_on   = 1'b0;
    int        rd_cnt   = 0;
    int        wr_cnt   = 0;
    fft_twdl_t tw_val;

    // scoreboard: read = {cycle, a, b, twiddle}, write = {cycle, a, b}
    logic [35:0] exp_rd_q[$];
    logic [29:0] exp_wr_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic int rel_now();
        return cyc - t0;
    endfunction

    function automatic bit rd_exp(input int c);
        for (int s = 0; s < AW; s++) begin
            if (c >= 1 + STG * s && c <= HALF + STG * s) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Schedule built group-by-group: pairs (g*2*span + k, +span), twiddle k*(N/2)/span.
    task automatic fill_model();
        int c;
        int span;
        int a;
        exp_rd_q.delete();
        exp_wr_q.delete();
        for (int s = 0; s < AW; s++) begin
            span = 1 << s;
            c    = 1 + STG * s;
            for (int g = 0; g < N / (2 * span); g++) begin
                for (int k = 0; k < span; k++) begin
                    a = g * 2 * span + k;
                    exp_rd_q.push_back({16'(c), 7'(a), 7'(a + span), 6'(k * (HALF / span))});
                    exp_wr_q.push_back({16'(c + D), 7'(a), 7'(a + span)});
                    c++;
                end
            end
        end
    endtask

    task automatic start_run();
        fill_model();
        rd_cnt = 0;
        wr_cnt = 0;
        t0     = cyc;
        start  = 1'b1;
        mon_on = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic wait_rel(input int r);
        while (rel_now() < r) step();
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("done_cycle", 32'(rel_now()), 32'(T_DONE));
    endtask

    task automatic check_idle(input string pre);
        chk({pre, "_busy"},    32'(busy), 32'd0);
        chk({pre, "_done"},    32'(done), 32'd0);
        chk({pre, "_state"},   32'(state_dbg), 32'(IDLE));
        chk({pre, "_rd_en"},   32'(bus.sram_rd_en_o), 32'd0);
        chk({pre, "_rd_a"},    32'(bus.sram_rd_addr_a_o), 32'd0);
        chk({pre, "_rd_b"},    32'(bus.sram_rd_addr_b_o), 32'd0);
        chk({pre, "_tw_rd"},   32'(bus.twdl_rd_addr_o), 32'd0);
        chk({pre, "_vld"},     32'(bus.bfly_vld_o), 32'd0);
        chk({pre, "_wr_en"},   32'(bus.sram_wr_en_o), 32'd0);
        chk({pre, "_wr_a"},    32'(bus.sram_wr_addr_a_o), 32'd0);
        chk({pre, "_wr_b"},    32'(bus.sram_wr_addr_b_o), 32'd0);
        chk({pre, "_tw_we"},   32'(bus.twdl_wr_en_o), 32'd0);
    endtask

    // monitor: per-cycle strobes plus scoreboard pops
    int          m_rel;
    logic [35:0] m_er;
    logic [29:0] m_ew;

    always @(negedge clk) begin
        if (mon_on) begin
            m_rel = cyc - t0;
            chk("rd_en",    32'(bus.sram_rd_en_o), 32'(rd_exp(m_rel)));
            chk("bfly_vld", 32'(bus.bfly_vld_o),   32'(rd_exp(m_rel - 1)));
            chk("wr_en",    32'(bus.sram_wr_en_o), 32'(rd_exp(m_rel - D)));
            chk("busy",     32'(busy), 32'(m_rel >= 1 && m_rel <= T_DONE));
            chk("done",     32'(done), 32'(m_rel == T_DONE));
            if (bus.sram_rd_en_o === 1'b1) begin
                rd_cnt++;
                chk("rd_q_nonempty", 32'(exp_rd_q.size() != 0), 32'd1);
                if (exp_rd_q.size() != 0) begin
                    m_er = exp_rd_q.pop_front();
                    chk("rd_cycle", 32'(m_rel), 32'(m_er[35:20]));
                    chk("rd_addr_a", 32'(bus.sram_rd_addr_a_o), 32'(m_er[19:13]));
                    chk("rd_addr_b", 32'(bus.sram_rd_addr_b_o), 32'(m_er[12:6]));
                    chk("twdl_idx", 32'(bus.twdl_rd_addr_o), 32'(m_er[5:0]));
                end
            end
            if (bus.sram_wr_en_o === 1'b1) begin
                wr_cnt++;
                chk("wr_q_nonempty", 32'(exp_wr_q.size() != 0), 32'd1);
                if (exp_wr_q.size() != 0) begin
                    m_ew = exp_wr_q.pop_front();
                    chk("wr_cycle", 32'(m_rel), 32'(m_ew[29:14]));
                    chk("wr_addr_a", 32'(bus.sram_wr_addr_a_o), 32'(m_ew[13:7]));
                    chk("wr_addr_b", 32'(bus.sram_wr_addr_b_o), 32'(m_ew[6:0]));
                end
            end
        end
    end

    initial begin
        rst                  = 1'b1;
        mode                 = NORMAL;
        start                = 1'b0;
        tw_val               = '{re: 10'h1FF, im: 10'h200};
        bus.cfg_twdl_wr_en_i = 1'b0;
        bus.cfg_twdl_addr_i  = '0;
        bus.cfg_twdl_data_i  = '0;
        repeat (3) step();
        check_idle("reset");
        rst = 1'b0;
        step();

        // twiddle load while idle in CONFIG
        mode                 = CONFIG;
        bus.cfg_twdl_wr_en_i = 1'b1;
        bus.cfg_twdl_addr_i  = 6'd3;
        bus.cfg_twdl_data_i  = tw_val;
        step();
        bus.cfg_twdl_wr_en_i = 1'b0;
        chk("twdl_idle_en",   32'(bus.twdl_wr_en_o), 32'd1);
        chk("twdl_idle_addr", 32'(bus.twdl_wr_addr_o), 32'd3);
        chk("twdl_idle_data", 32'(bus.twdl_wr_data_o), 32'h7FE00);
        step();
        chk("twdl_one_shot", 32'(bus.twdl_wr_en_o), 32'd0);

        // start is ignored in CONFIG
        start = 1'b1;
        step();
        start = 1'b0;
        chk("cfg_start_busy", 32'(busy), 32'd0);
        chk("cfg_start_state", 32'(state_dbg), 32'(IDLE));
        mode = NORMAL;
        step();

        // run 1: stray start at 100, CONFIG at 200, twiddle write while busy at 300
        start_run();
        wait_rel(100);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_rel(200);
        mode = CONFIG;
        wait_rel(300);
        bus.cfg_twdl_wr_en_i = 1'b1;
        step();
        bus.cfg_twdl_wr_en_i = 1'b0;
        chk("twdl_busy_drop", 32'(bus.twdl_wr_en_o), 32'd0);
        wait_done();
        chk("run1_reads",  32'(rd_cnt), 32'd448);
        chk("run1_writes", 32'(wr_cnt), 32'd448);
        chk("run1_rd_q_left", 32'(exp_rd_q.size()), 32'd0);
        chk("run1_wr_q_left", 32'(exp_wr_q.size()), 32'd0);
        mode = NORMAL;
        step();

        // run 2: start on the cycle after DONE, then reset at cycle 250
        start_run();
        wait_rel(250);
        mon_on = 1'b0;
        rst    = 1'b1;
        step();
        check_idle("mid_reset");
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("post_rst_wr_en", 32'(bus.sram_wr_en_o), 32'd0);
            chk("post_rst_rd_en", 32'(bus.sram_rd_en_o), 32'd0);
        end

        // run 3: clean restart after reset
        start_run();
        wait_done();
        chk("run3_reads",  32'(rd_cnt), 32'd448);
        chk("run3_writes", 32'(wr_cnt), 32'd448);
        step();
        step();
        mon_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
